// File: rtl/jt10_adpcma_ctrl.sv
// ============================================================================
// Module      : jt10_adpcma_ctrl
// Description : ADPCM-A register-write sequencer. Holds per-channel key and
//               address updates and issues them in the channel's pipeline slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt10_adpcma_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        wr_n,
  input  logic [7:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic [5:0]  cur_ch,
  output logic        aon,
  output logic        aoff,
  output logic [15:0] addr_in,
  output logic [2:0]  addr_ch,
  output logic        up_start,
  output logic        up_end,
  output logic        busy
);

  localparam logic [4:0] GRP_ST_LO  = 5'b00010;  // 0x10-0x17
  localparam logic [4:0] GRP_ST_HI  = 5'b00011;  // 0x18-0x1F
  localparam logic [4:0] GRP_END_LO = 5'b00100;  // 0x20-0x27
  localparam logic [4:0] GRP_END_HI = 5'b00101;  // 0x28-0x2F

  logic [5:0]  r_cur_ch;
  logic [5:0]  r_pon, r_poff, r_pst, r_pend;
  logic [5:0]  w_pon, w_poff, w_pst, w_pend;
  logic [15:0] r_start [0:5];
  logic [15:0] r_end   [0:5];
  logic [2:0]  w_idx;
  logic [2:0]  w_wr_ch;
  logic        w_wr, w_ch_ok;
  logic        w_key, w_st_lo, w_st_hi, w_end_lo, w_end_hi;
  logic        w_up_start, w_up_end;

  // Write decode
  assign w_wr     = ~wr_n;
  assign w_wr_ch  = wr_addr[2:0];
  assign w_ch_ok  = (w_wr_ch < 3'd6);
  assign w_key    = w_wr && (wr_addr == 8'h00);
  assign w_st_lo  = w_wr && w_ch_ok && (wr_addr[7:3] == GRP_ST_LO);
  assign w_st_hi  = w_wr && w_ch_ok && (wr_addr[7:3] == GRP_ST_HI);
  assign w_end_lo = w_wr && w_ch_ok && (wr_addr[7:3] == GRP_END_LO);
  assign w_end_hi = w_wr && w_ch_ok && (wr_addr[7:3] == GRP_END_HI);

  always_comb begin
    w_idx = 3'd0;
    case (r_cur_ch)
      6'b000001: w_idx = 3'd0;
      6'b000010: w_idx = 3'd1;
      6'b000100: w_idx = 3'd2;
      6'b001000: w_idx = 3'd3;
      6'b010000: w_idx = 3'd4;
      6'b100000: w_idx = 3'd5;
      default:   w_idx = 3'd0;
    endcase
  end

  // Consumption is applied first so that a same-edge write overrides it
  always_comb begin
    w_pon  = r_pon;
    w_poff = r_poff;
    w_pst  = r_pst;
    w_pend = r_pend;
    if (cen) begin
      w_pon[w_idx]  = 1'b0;
      w_poff[w_idx] = 1'b0;
      if (r_pst[w_idx]) w_pst[w_idx]  = 1'b0;
      else              w_pend[w_idx] = 1'b0;
    end
    if (w_key) begin
      for (int i = 0; i < 6; i++) begin
        if (wr_data[i]) begin
          w_poff[i] = wr_data[7];
          w_pon[i]  = ~wr_data[7];
        end
      end
    end
    if (w_st_hi)  w_pst[w_wr_ch]  = 1'b1;
    if (w_end_hi) w_pend[w_wr_ch] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_ch <= 6'b000001;
      r_pon    <= '0;
      r_poff   <= '0;
      r_pst    <= '0;
      r_pend   <= '0;
    end else begin
      if (cen) r_cur_ch <= {r_cur_ch[4:0], r_cur_ch[5]};
      r_pon  <= w_pon;
      r_poff <= w_poff;
      r_pst  <= w_pst;
      r_pend <= w_pend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        r_start[i] <= '0;
        r_end[i]   <= '0;
      end
    end else begin
      if (w_st_lo)  r_start[w_wr_ch][7:0]  <= wr_data;
      if (w_st_hi)  r_start[w_wr_ch][15:8] <= wr_data;
      if (w_end_lo) r_end[w_wr_ch][7:0]    <= wr_data;
      if (w_end_hi) r_end[w_wr_ch][15:8]   <= wr_data;
    end
  end

  // Start has priority; a pending end waits for the channel's next slot
  assign w_up_start = r_pst[w_idx];
  assign w_up_end   = ~r_pst[w_idx] & r_pend[w_idx];

  assign cur_ch   = r_cur_ch;
  assign aon      = r_pon[w_idx];
  assign aoff     = r_poff[w_idx];
  assign up_start = w_up_start;
  assign up_end   = w_up_end;
  assign addr_in  = w_up_start ? r_start[w_idx] :
                    w_up_end   ? r_end[w_idx]   : 16'h0000;
  assign addr_ch  = (w_up_start | w_up_end) ? w_idx : 3'd0;
  assign busy     = |{r_pon, r_poff, r_pst, r_pend};

endmodule

`default_nettype wire

// File: tb/tb_jt10_adpcma_ctrl.sv
// ============================================================================
// Module      : tb_jt10_adpcma_ctrl
// Description : Scoreboard testbench for jt10_adpcma_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jt10_adpcma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        wr_n = 1'b1;
  logic [7:0]  wr_addr = 8'h00;
  logic [7:0]  wr_data = 8'h00;
  logic [5:0]  cur_ch;
  logic        aon, aoff, up_start, up_end, busy;
  logic [15:0] addr_in;
  logic [2:0]  addr_ch;

  jt10_adpcma_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wr_n(wr_n),
    .wr_addr(wr_addr), .wr_data(wr_data), .cur_ch(cur_ch),
    .aon(aon), .aoff(aoff), .addr_in(addr_in), .addr_ch(addr_ch),
    .up_start(up_start), .up_end(up_end), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  ch;
    logic        aon, aoff, ups, upe;
    logic [15:0] ain;
    logic [2:0]  ach;
    logic        busy;
  } rec_t;

  rec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   slot = 0;
  int   ncen = 0;

  function automatic void expect_rec(int s, bit e_aon, bit e_aoff, bit e_ups, bit e_upe,
                                     logic [15:0] e_ain, logic [2:0] e_ach, bit e_busy);
    rec_t r;
    r.ch   = 6'(1 << s);
    r.aon  = e_aon;
    r.aoff = e_aoff;
    r.ups  = e_ups;
    r.upe  = e_upe;
    r.ain  = e_ain;
    r.ach  = e_ach;
    r.busy = e_busy;
    sb.push_back(r);
  endfunction

  // What the address counter sees on each cen
  always @(negedge clk) begin
    if (cen) begin
      rec_t got, e;
      got = {cur_ch, aon, aoff, up_start, up_end, addr_in, addr_ch, busy};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow cen=%0d got ch=%h aon=%b aoff=%b us=%b ue=%b ain=%h ach=%0d busy=%b",
                 ncen, got.ch, got.aon, got.aoff, got.ups, got.upe, got.ain, got.ach, got.busy);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL sb_cen%0d got ch=%h aon=%b aoff=%b us=%b ue=%b ain=%h ach=%0d busy=%b exp ch=%h aon=%b aoff=%b us=%b ue=%b ain=%h ach=%0d busy=%b",
                   ncen, got.ch, got.aon, got.aoff, got.ups, got.upe, got.ain, got.ach, got.busy,
                   e.ch, e.aon, e.aoff, e.ups, e.upe, e.ain, e.ach, e.busy);
        end
      end
      ncen++;
    end
  end

  task automatic pulse_cen();
    @(posedge clk); #1 cen = 1'b1;
    @(posedge clk); #1 cen = 1'b0;
    slot = (slot + 1) % 6;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1 wr_n = 1'b0; wr_addr = a; wr_data = d;
    @(posedge clk); #1 wr_n = 1'b1;
  endtask

  task automatic goto_slot(input int s);
    while (slot != s) begin
      expect_rec(slot, 0, 0, 0, 0, 16'h0, 3'd0, 0);
      pulse_cen();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    checks++;
    if ({cur_ch, aon, aoff, up_start, up_end, addr_in, addr_ch, busy} !== {6'h01, 4'b0, 16'h0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got ch=%h aon=%b aoff=%b us=%b ue=%b ain=%h ach=%0d busy=%b",
               cur_ch, aon, aoff, up_start, up_end, addr_in, addr_ch, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    slot = 0;
    for (int k = 0; k < 12; k++) begin
      expect_rec(k % 6, 0, 0, 0, 0, 16'h0, 3'd0, 0);
      pulse_cen();
    end
  endtask

  task automatic test_keyon();
    goto_slot(1);
    cpu_wr(8'h00, 8'h05);
    expect_rec(1, 0, 0, 0, 0, 16'h0, 3'd0, 1);
    expect_rec(2, 1, 0, 0, 0, 16'h0, 3'd0, 1);
    expect_rec(3, 0, 0, 0, 0, 16'h0, 3'd0, 1);
    expect_rec(4, 0, 0, 0, 0, 16'h0, 3'd0, 1);
    expect_rec(5, 0, 0, 0, 0, 16'h0, 3'd0, 1);
    expect_rec(0, 1, 0, 0, 0, 16'h0, 3'd0, 1);
    expect_rec(1, 0, 0, 0, 0, 16'h0, 3'd0, 0);
    repeat (7) pulse_cen();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL keyon_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_addr();
    goto_slot(0);
    cpu_wr(8'h13, 8'h34);
    cpu_wr(8'h1B, 8'h12);
    cpu_wr(8'h23, 8'h78);
    cpu_wr(8'h2B, 8'h56);
    for (int s = 0; s < 3; s++) expect_rec(s, 0, 0, 0, 0, 16'h0, 3'd0, 1);
    expect_rec(3, 0, 0, 1, 0, 16'h1234, 3'd3, 1);
    for (int s = 4; s < 9; s++) expect_rec(s % 6, 0, 0, 0, 0, 16'h0, 3'd0, 1);
    expect_rec(3, 0, 0, 0, 1, 16'h5678, 3'd3, 1);
    expect_rec(4, 0, 0, 0, 0, 16'h0, 3'd0, 0);
    repeat (11) pulse_cen();
  endtask

  task automatic test_ignored();
    cpu_wr(8'h14, 8'hAA);
    cpu_wr(8'h16, 8'h11);
    cpu_wr(8'h1E, 8'h22);
    cpu_wr(8'h2E, 8'h33);
    cpu_wr(8'h05, 8'h3F);
    cpu_wr(8'h01, 8'h3F);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_key_override();
    goto_slot(5);
    cpu_wr(8'h00, 8'h02);
    cpu_wr(8'h00, 8'h82);
    expect_rec(5, 0, 0, 0, 0, 16'h0, 3'd0, 1);
    expect_rec(0, 0, 0, 0, 0, 16'h0, 3'd0, 1);
    expect_rec(1, 0, 1, 0, 0, 16'h0, 3'd0, 1);
    expect_rec(2, 0, 0, 0, 0, 16'h0, 3'd0, 0);
    repeat (4) pulse_cen();
  endtask

  task automatic test_back_to_back();
    goto_slot(0);
    cpu_wr(8'h10, 8'h11);
    cpu_wr(8'h18, 8'h22);
    expect_rec(0, 0, 0, 1, 0, 16'h2211, 3'd0, 1);
    // high-byte rewrite lands on the consuming edge
    @(posedge clk); #1 cen = 1'b1; wr_n = 1'b0; wr_addr = 8'h18; wr_data = 8'h33;
    @(posedge clk); #1 cen = 1'b0; wr_n = 1'b1;
    slot = 1;
    for (int s = 1; s < 6; s++) expect_rec(s, 0, 0, 0, 0, 16'h0, 3'd0, 1);
    expect_rec(0, 0, 0, 1, 0, 16'h3311, 3'd0, 1);
    expect_rec(1, 0, 0, 0, 0, 16'h0, 3'd0, 0);
    repeat (7) pulse_cen();
  endtask

  task automatic test_reset_mid();
    cpu_wr(8'h00, 8'h08);
    cpu_wr(8'h1C, 8'h99);
    expect_rec(2, 0, 0, 0, 0, 16'h0, 3'd0, 1);
    pulse_cen();
    #2;
    checks++;
    if ({cur_ch, aon, busy} !== {6'h08, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset got ch=%h aon=%b busy=%b exp ch=08 aon=1 busy=1", cur_ch, aon, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cur_ch, aon, aoff, up_start, up_end, addr_in, addr_ch, busy} !== {6'h01, 4'b0, 16'h0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got ch=%h aon=%b aoff=%b us=%b ue=%b ain=%h ach=%0d busy=%b",
               cur_ch, aon, aoff, up_start, up_end, addr_in, addr_ch, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    slot = 0;
    for (int k = 0; k < 12; k++) begin
      expect_rec(k % 6, 0, 0, 0, 0, 16'h0, 3'd0, 0);
      pulse_cen();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_keyon();
    test_addr();
    test_ignored();
    test_key_override();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d entries exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
